// File: rtl/dice_or_light_param.sv
// Two-mode LED block: N-face die (sel=0) or UK traffic light with parameterised dwell times (sel=1).
// Optional pedestrian request in green is enabled with the PED_REQUEST_EN macro.
module dice_or_light_param #(
    parameter int W         = 3,
    parameter int FACES     = 6,
    parameter int RED_CYC   = 4,
    parameter int RA_CYC    = 1,
    parameter int GREEN_CYC = 4,
    parameter int AMBER_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         button,
    input  logic         sel,
    output logic [W-1:0] result,
    output logic         rolling,
    output logic         phase_tick
);

    localparam int MAX_A   = (RED_CYC > RA_CYC) ? RED_CYC : RA_CYC;
    localparam int MAX_B   = (GREEN_CYC > AMBER_CYC) ? GREEN_CYC : AMBER_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = (MAX_CYC <= 1) ? 1 : $clog2(MAX_CYC);

`ifdef PED_REQUEST_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    typedef logic [CW-1:0] cnt_t;

    // Light state encodings double as the {red, amber, green} LED pattern.
    typedef enum logic [2:0] {
        RED     = 3'b100,
        RED_AMB = 3'b110,
        GREEN   = 3'b001,
        AMBER   = 3'b010
    } light_t;

    localparam logic [W-1:0] DIE_ONE  = W'(1);
    localparam logic [W-1:0] DIE_MAX  = W'(FACES);
    localparam logic [W-1:0] L_RED    = W'(3'b100);
    localparam logic [W-1:0] L_RA     = W'(3'b110);
    localparam logic [W-1:0] L_GREEN  = W'(3'b001);
    localparam logic [W-1:0] L_AMBER  = W'(3'b010);

    logic [W-1:0] result_q, result_d;
    logic         rolling_q, rolling_d;
    logic         tick_q, tick_d;
    logic         sel_q;
    cnt_t         cnt_q, cnt_d;
    light_t       light_cur, light_nxt;
    logic         light_ok;
    cnt_t         last_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q  <= sel ? L_RED : DIE_ONE;
            rolling_q <= 1'b0;
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            sel_q     <= sel;
        end else begin
            result_q  <= result_d;
            rolling_q <= rolling_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel;
        end
    end

    always_comb begin
        light_cur = RED;
        light_ok  = 1'b1;
        case (result_q)
            L_RED:   light_cur = RED;
            L_RA:    light_cur = RED_AMB;
            L_GREEN: light_cur = GREEN;
            L_AMBER: light_cur = AMBER;
            default: light_ok  = 1'b0;
        endcase

        case (light_cur)
            RED:     begin light_nxt = RED_AMB; last_cnt = cnt_t'(RED_CYC - 1);   end
            RED_AMB: begin light_nxt = GREEN;   last_cnt = cnt_t'(RA_CYC - 1);    end
            GREEN:   begin light_nxt = AMBER;   last_cnt = cnt_t'(GREEN_CYC - 1); end
            default: begin light_nxt = RED;     last_cnt = cnt_t'(AMBER_CYC - 1); end
        endcase
    end

    always_comb begin
        result_d  = result_q;
        rolling_d = 1'b0;
        tick_d    = 1'b0;
        cnt_d     = cnt_q;

        if (sel != sel_q) begin
            result_d = sel ? L_RED : DIE_ONE;
            cnt_d    = '0;
        end else if (!sel) begin
            cnt_d     = '0;
            rolling_d = button;
            if (result_q == '0 || result_q > DIE_MAX)
                result_d = DIE_ONE;
            else if (button)
                result_d = (result_q == DIE_MAX) ? DIE_ONE : result_q + DIE_ONE;
        end else if (!light_ok) begin
            result_d = L_RED;
            cnt_d    = '0;
        end else if (PED_EN && button && light_cur == GREEN && cnt_q != '0) begin
            // Pedestrian request cuts green short; never latched in other phases.
            result_d = L_AMBER;
            cnt_d    = '0;
            tick_d   = 1'b1;
        end else if (cnt_q == last_cnt) begin
            result_d = W'(light_nxt);
            cnt_d    = '0;
            tick_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    assign result     = result_q;
    assign rolling    = rolling_q;
    assign phase_tick = tick_q;

endmodule

// File: tb/tb_dice_or_light_param.sv
// Scoreboard bench for dice_or_light_param: driver pushes expected {result, rolling, phase_tick}
// per edge, a monitor pops and compares after every rising edge.
module tb_dice_or_light_param;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         button;
    logic         sel;
    logic [W-1:0] result;
    logic         rolling;
    logic         phase_tick;

    int checks = 0;
    int errors = 0;

    logic [W+1:0] exp_q[$];
    string        name_q[$];

    dice_or_light_param dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .sel        (sel),
        .result     (result),
        .rolling    (rolling),
        .phase_tick (phase_tick)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; expectation is what the next rising edge registers.
    task automatic step(input logic r, input logic s, input logic b,
                        input int res, input logic roll, input logic tick, input string nm);
        @(negedge clk);
        rst    = r;
        sel    = s;
        button = b;
        exp_q.push_back({W'(res), roll, tick});
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    logic [W+1:0] exp_v;
    string        nm_v;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm_v  = name_q.pop_front();
            checks++;
            if ({result, rolling, phase_tick} !== exp_v) begin
                errors++;
                $display("FAIL %s: got result=%b rolling=%b tick=%b, expected result=%b rolling=%b tick=%b",
                         nm_v, result, rolling, phase_tick, exp_v[W+1:2], exp_v[1], exp_v[0]);
            end
        end
    end

    int   lres[10] = '{4, 4, 4, 6, 1, 1, 1, 1, 2, 4};
    logic ltk[10]  = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    int   dv[8]    = '{2, 3, 4, 5, 6, 1, 2, 3};

    initial begin
        rst    = 1'b0;
        sel    = 1'b0;
        button = 1'b0;

        step(0, 0, 0, 1, 0, 0, "reset_dice");
        step(0, 0, 0, 1, 0, 0, "reset_dice");
        step(0, 1, 0, 4, 0, 0, "reset_light");

        for (int k = 0; k < 20; k++)
            step(1, 1, 0, lres[k % 10], 0, ltk[k % 10], "light_seq");

        step(1, 0, 0, 1, 0, 0, "to_dice");
        for (int i = 0; i < 8; i++)
            step(1, 0, 1, dv[i], 1, 0, "dice_wrap");
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 3, 0, 0, "dice_hold");

        step(1, 0, 1, 4, 1, 0, "dice_roll4");
        step(1, 1, 1, 4, 0, 0, "switch_to_light");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 4, 0, 0, "red_full");
        step(1, 1, 0, 6, 0, 1, "red_amb");
        step(1, 1, 0, 1, 0, 1, "green_enter");
        step(1, 1, 0, 1, 0, 0, "green_c1");
        step(0, 1, 0, 4, 0, 0, "reset_mid");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 4, 0, 0, "red_after_rst");
        step(1, 1, 0, 6, 0, 1, "red_amb_after_rst");
        step(1, 0, 0, 1, 0, 0, "back_to_dice");

        step(1, 1, 1, 4, 0, 0, "ped_switch");
        for (int i = 0; i < 3; i++)
            step(1, 1, 1, 4, 0, 0, "ped_red_ignored");
        step(1, 1, 1, 6, 0, 1, "ped_ra_ignored");
        step(1, 1, 1, 1, 0, 1, "ped_green_enter");
        step(1, 1, 1, 1, 0, 0, "ped_green_c0_ignored");
`ifdef PED_REQUEST_EN
        step(1, 1, 1, 2, 0, 1, "ped_truncate");
        step(1, 1, 0, 4, 0, 1, "ped_amber_done");
`else
        step(1, 1, 1, 1, 0, 0, "green_c2");
        step(1, 1, 1, 1, 0, 0, "green_c3");
        step(1, 1, 1, 2, 0, 1, "green_full_amber");
        step(1, 1, 0, 4, 0, 1, "amber_to_red");
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
